// File: rtl/c3lib_rst_seq_pkg.sv
// Shared types and helpers for the staged reset-release sequencer.
package c3lib_rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REL    = 2'd2,
        ST_DONE   = 2'd3
    } rst_seq_st_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/c3lib_rst_seq_cnt.sv
// Loadable down-counter with zero flag; saturates at zero so it never wraps.
module c3lib_rst_seq_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/c3lib_rst_seq_gen.sv
// Staged reset-release sequencer: holds all active-low stage resets, then
// releases them one per GAP_CYC after HOLD_CYC, stage 0 first.
module c3lib_rst_seq_gen
    import c3lib_rst_seq_pkg::*;
#(
    parameter int NUM_STG  = 4,
    parameter int HOLD_CYC = 8,
    parameter int GAP_CYC  = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               sw_rst_req_i,
    output logic [NUM_STG-1:0] rst_n_out_o,
    output logic               seq_done_o,
    output logic               seq_busy_o
);

    localparam int CNT_W = $clog2(max2(HOLD_CYC, GAP_CYC) + 1);
    localparam int IDX_W = $clog2(NUM_STG) + 1;

    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STG - 1);

    if (NUM_STG < 1 || NUM_STG > 16) begin : g_bad_num_stg
        $error("c3lib_rst_seq_gen: NUM_STG must be in 1..16");
    end
    if (HOLD_CYC < 1) begin : g_bad_hold
        $error("c3lib_rst_seq_gen: HOLD_CYC must be >= 1");
    end
    if (GAP_CYC < 1) begin : g_bad_gap
        $error("c3lib_rst_seq_gen: GAP_CYC must be >= 1");
    end

    rst_seq_st_t        state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_STG-1:0] rst_n_q, rst_n_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               cnt_ld, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]   cnt_ld_val;
    logic               abort;

    assign abort = ~en_i | sw_rst_req_i;

    c3lib_rst_seq_cnt #(.W(CNT_W)) u_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_ld),
        .load_val_i (cnt_ld_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rst_n_d    = rst_n_q;
        done_d     = done_q;
        busy_d     = busy_q;
        cnt_ld     = 1'b0;
        cnt_ld_val = '0;
        cnt_dec    = 1'b0;

        if (abort) begin
            state_d = ST_ASSERT;
            idx_d   = '0;
            rst_n_d = '0;
            done_d  = 1'b0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_ASSERT: begin
                    state_d    = ST_HOLD;
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    cnt_ld     = 1'b1;
                    cnt_ld_val = HOLD_LD;
                end
                // HOLD is just the first release step with idx 0 and a longer wait
                ST_HOLD, ST_REL: begin
                    if (cnt_zero) begin
                        for (int k = 0; k < NUM_STG; k++) begin
                            if (idx_q == IDX_W'(k)) rst_n_d[k] = 1'b1;
                        end
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d    = ST_REL;
                            idx_d      = idx_q + IDX_W'(1);
                            cnt_ld     = 1'b1;
                            cnt_ld_val = GAP_LD;
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_d = ST_ASSERT;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_ASSERT;
            idx_q   <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rst_n_q <= rst_n_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign rst_n_out_o = rst_n_q;
    assign seq_done_o  = done_q;
    assign seq_busy_o  = busy_q;

endmodule
